// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command handler: command codes, reply
// source codes and the reply FSM state type.
package spi_cmd_pkg;

    localparam int ADR_W = 3;

    localparam logic [ADR_W-1:0] CMD_NOP    = 3'd0;
    localparam logic [ADR_W-1:0] CMD_LEDA   = 3'd1;
    localparam logic [ADR_W-1:0] CMD_LEDB   = 3'd2;
    localparam logic [ADR_W-1:0] CMD_BRIGHT = 3'd3;
    localparam logic [ADR_W-1:0] CMD_RSEL   = 3'd4;
    localparam logic [ADR_W-1:0] CMD_CLRLAT = 3'd5;
    localparam logic [ADR_W-1:0] CMD_SOFTCLR = 3'd6;
    localparam logic [ADR_W-1:0] CMD_RSVD   = 3'd7;

    localparam logic [1:0] REPLY_KEYS  = 2'd0;
    localparam logic [1:0] REPLY_LATCH = 2'd1;
    localparam logic [1:0] REPLY_LEDA  = 2'd2;
    localparam logic [1:0] REPLY_VER   = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } reply_state_t;

endpackage

// File: rtl/spi_cmd_handler_key_debounce.sv
// One keyboard line: 2-FF synchroniser followed by a saturating stability
// counter. The debounced level only follows the synced input after it has
// differed continuously for 2**DEB_CNT_W cycles; rise pulses for one cycle
// on a 0->1 change of the debounced level.
module key_debounce #(
    parameter int DEB_CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic rise
);

    logic                 s1_reg;
    logic                 s2_reg;
    logic                 level_reg;
    logic                 rise_reg;
    logic [DEB_CNT_W-1:0] cnt_reg;

    // Synchronise, count how long the synced value disagrees, commit on saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            s1_reg   <= key;
            s2_reg   <= s1_reg;
            rise_reg <= 1'b0;
            if (s2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (&cnt_reg) begin
                level_reg <= s2_reg;
                rise_reg  <= s2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/spi_cmd_handler.sv
// SPI command handler: brings SPI slave commands into the clk domain,
// executes them on LED / reply-select / key-latch registers, debounces the
// keyboard and drives a frame-stable replyData back to the SPI slave.
// Optional feature macro: SPI_CMD_PWM_EN (brightness PWM on ledOut).
module spi_cmd_handler
    import spi_cmd_pkg::*;
#(
    parameter int                    COMM_WIDTH = 8,
    parameter int                    ADR_WIDTH  = 3,
    parameter int                    KEY_NUM    = 8,
    parameter int                    DEB_CNT_W  = 16,
    parameter logic [COMM_WIDTH-1:0] VERSION    = 'h11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COMM_WIDTH-1:0] commData,
    input  logic [ADR_WIDTH-1:0]  commAdr,
    input  logic                  commReady,
    input  logic                  sel,
    input  logic [KEY_NUM-1:0]    keys,
    output logic [COMM_WIDTH-1:0] replyData,
    output logic [15:0]           ledOut,
    output logic                  keyIrq
);

    logic                  cr_s1_reg, cr_s2_reg, cr_d_reg;
    logic                  sel_s1_reg, sel_s2_reg;
    logic                  cmd_valid_reg;
    logic [ADR_WIDTH-1:0]  cmd_adr_reg;
    logic [COMM_WIDTH-1:0] cmd_data_reg;
    logic [7:0]            led_a_reg, led_b_reg;
    logic [1:0]            reply_sel_reg;
    logic [KEY_NUM-1:0]    latch_reg;
    logic                  key_irq_reg;
    logic [KEY_NUM-1:0]    keys_deb;
    logic [KEY_NUM-1:0]    keys_rise;
    logic [COMM_WIDTH-1:0] reply_src;
    logic [COMM_WIDTH-1:0] reply_data_reg;
    reply_state_t          state_reg, state_next;
`ifdef SPI_CMD_PWM_EN
    logic [7:0]            bright_reg;
    logic [7:0]            pwm_cnt_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < KEY_NUM; gi++) begin : g_key
            key_debounce #(.DEB_CNT_W(DEB_CNT_W)) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .key   (keys[gi]),
                .level (keys_deb[gi]),
                .rise  (keys_rise[gi])
            );
        end
    endgenerate

    // Cross commReady and sel into clk; sel idles high so reset is "no frame"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_s1_reg  <= 1'b0;
            cr_s2_reg  <= 1'b0;
            cr_d_reg   <= 1'b0;
            sel_s1_reg <= 1'b1;
            sel_s2_reg <= 1'b1;
        end else begin
            cr_s1_reg  <= commReady;
            cr_s2_reg  <= cr_s1_reg;
            cr_d_reg   <= cr_s2_reg;
            sel_s1_reg <= sel;
            sel_s2_reg <= sel_s1_reg;
        end
    end

    // Sample the (quasi-static) command bus on the synced commReady rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_reg <= 1'b0;
            cmd_adr_reg   <= '0;
            cmd_data_reg  <= '0;
        end else begin
            cmd_valid_reg <= cr_s2_reg & ~cr_d_reg;
            if (cr_s2_reg & ~cr_d_reg) begin
                cmd_adr_reg  <= commAdr;
                cmd_data_reg <= commData;
            end
        end
    end

    // Execute the captured command; key presses always win over clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_a_reg     <= '0;
            led_b_reg     <= '0;
            reply_sel_reg <= REPLY_KEYS;
            latch_reg     <= '0;
`ifdef SPI_CMD_PWM_EN
            bright_reg    <= 8'hFF;
`endif
        end else begin
            latch_reg <= latch_reg | keys_rise;
            if (cmd_valid_reg) begin
                case (cmd_adr_reg)
                    CMD_LEDA:   led_a_reg     <= cmd_data_reg[7:0];
                    CMD_LEDB:   led_b_reg     <= cmd_data_reg[7:0];
`ifdef SPI_CMD_PWM_EN
                    CMD_BRIGHT: bright_reg    <= cmd_data_reg[7:0];
`endif
                    CMD_RSEL:   reply_sel_reg <= cmd_data_reg[1:0];
                    CMD_CLRLAT: latch_reg     <= (latch_reg & ~cmd_data_reg[KEY_NUM-1:0]) | keys_rise;
                    CMD_SOFTCLR: begin
                        led_a_reg     <= '0;
                        led_b_reg     <= '0;
                        reply_sel_reg <= REPLY_KEYS;
                        latch_reg     <= keys_rise;
`ifdef SPI_CMD_PWM_EN
                        bright_reg    <= 8'hFF;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Interrupt flag tracks the latched presses one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_irq_reg <= 1'b0;
        else        key_irq_reg <= |latch_reg;
    end

    assign keyIrq = key_irq_reg;

`ifdef SPI_CMD_PWM_EN
    // Free-running PWM phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt_reg <= '0;
        else        pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
    end

    assign ledOut = {led_b_reg, led_a_reg} & {16{pwm_cnt_reg < bright_reg}};
`else
    assign ledOut = {led_b_reg, led_a_reg};
`endif

    // Reply source selection, narrower sources zero-extended
    always_comb begin
        reply_src = '0;
        case (reply_sel_reg)
            REPLY_KEYS:  reply_src[KEY_NUM-1:0] = keys_deb;
            REPLY_LATCH: reply_src[KEY_NUM-1:0] = latch_reg;
            REPLY_LEDA:  reply_src[7:0]         = led_a_reg;
            default:     reply_src              = VERSION;
        endcase
    end

    // Reply FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Reply FSM next state: a frame lasts while synced sel is low
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!sel_s2_reg) state_next = ST_FRAME;
            ST_FRAME: if (sel_s2_reg)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // replyData follows the source only outside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  reply_data_reg <= '0;
        else if (state_reg == ST_IDLE) reply_data_reg <= reply_src;
    end

    assign replyData = reply_data_reg;

endmodule

// File: tb/tb_spi_cmd_handler.sv
// Directed bench for spi_cmd_handler with a short debounce (DEB_CNT_W=4).
// Honours SPI_CMD_PWM_EN the same way as the design.
module tb_spi_cmd_handler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  commData = '0;
    logic [2:0]  commAdr = '0;
    logic        commReady = 1'b0;
    logic        sel = 1'b1;
    logic [7:0]  keys = '0;
    logic [7:0]  replyData;
    logic [15:0] ledOut;
    logic        keyIrq;

    int total = 0;
    int bad   = 0;

    spi_cmd_handler #(
        .COMM_WIDTH (8),
        .ADR_WIDTH  (3),
        .KEY_NUM    (8),
        .DEB_CNT_W  (4),
        .VERSION    (8'h11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .commData  (commData),
        .commAdr   (commAdr),
        .commReady (commReady),
        .sel       (sel),
        .keys      (keys),
        .replyData (replyData),
        .ledOut    (ledOut),
        .keyIrq    (keyIrq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] adr, input logic [7:0] data);
        commAdr   = adr;
        commData  = data;
        commReady = 1'b1;
        tick(6);
        commReady = 1'b0;
        tick(6);
    endtask

    initial begin
        int on_cnt;
        tick(2);
        check("reset_reply", replyData, 8'h00);
        check("reset_led", ledOut, 16'h0000);
        check("reset_irq", keyIrq, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // 1: ledA write, exact 4-clk latency, ledB untouched
        commAdr = 3'd1; commData = 8'hA5; commReady = 1'b1;
        tick(3);
        check("cmd1_lat3", ledOut, 16'h0000);
        tick(1);
        check("cmd1_lat4", ledOut, 16'h00A5);
        tick(2);
        commReady = 1'b0;
        tick(6);
        check("cmd1_ledb", ledOut[15:8], 8'h00);

        // 2: stable key press latches; W1C clears
        keys[2] = 1'b1;
        tick(25);
        check("key2_deb", replyData, 8'h04);
        check("key2_irq", keyIrq, 1'b1);
        send_cmd(3'd4, 8'h01);
        check("key2_latch", replyData, 8'h04);
        send_cmd(3'd5, 8'h04);
        check("clr_latch", replyData, 8'h00);
        check("clr_irq", keyIrq, 1'b0);

        // 3: short glitch is rejected
        keys[0] = 1'b1;
        tick(10);
        keys[0] = 1'b0;
        tick(20);
        check("glitch_latch", replyData, 8'h00);
        check("glitch_irq", keyIrq, 1'b0);
        send_cmd(3'd4, 8'h00);
        check("glitch_deb", replyData, 8'h04);

        // 4: reply frozen during a frame
        send_cmd(3'd4, 8'h03);
        check("reply_ver", replyData, 8'h11);
        sel = 1'b0;
        tick(4);
        send_cmd(3'd1, 8'h3C);
        send_cmd(3'd4, 8'h02);
        check("frame_led_now", ledOut[7:0], 8'h3C);
        check("frame_frozen", replyData, 8'h11);
        sel = 1'b1;
        tick(4);
        check("frame_end_leda", replyData, 8'h3C);

        // 5: brightness
        send_cmd(3'd1, 8'hFF);
        send_cmd(3'd3, 8'h40);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            if (ledOut[0]) on_cnt++;
        end
`ifdef SPI_CMD_PWM_EN
        check("pwm_on_cnt", on_cnt, 64);
`else
        check("pwm_on_cnt", on_cnt, 256);
`endif

        // cmd 2, ignored cmd 7, soft clear
        send_cmd(3'd2, 8'h5A);
        check("ledb_write", ledOut[15:8], 8'h5A);
        send_cmd(3'd7, 8'h00);
        check("cmd7_ignored", ledOut[15:8], 8'h5A);
        send_cmd(3'd6, 8'h00);
        check("softclr_led", ledOut, 16'h0000);
        check("softclr_reply", replyData, 8'h04);

        // 6: async reset in the middle of a frame
        keys[2] = 1'b0;
        keys[3] = 1'b1;
        send_cmd(3'd1, 8'h81);
        send_cmd(3'd4, 8'h02);
        tick(20);
        check("pre_rst_irq", keyIrq, 1'b1);
        sel = 1'b0;
        tick(4);
        check("pre_rst_reply", replyData, 8'h81);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_reply", replyData, 8'h00);
        check("rst_async_led", ledOut, 16'h0000);
        check("rst_async_irq", keyIrq, 1'b0);
        tick(2);
        keys = '0;
        sel  = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send_cmd(3'd4, 8'h03);
        check("post_rst_idle", replyData, 8'h11);
        check("post_rst_led", ledOut, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
